// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl
// Runs one CPU data-space access per request. The target is the synchronous
// data SRAM, the I/O register file, or nothing: the register-file window and
// out-of-range SRAM addresses complete without a strobe and read as 0x00.
// Every output is registered. Address, data and target are latched when the
// request is accepted in IDLE and are held for the whole access.
module dm_access_ctrl #(
  parameter int DM_AW   = 11,
  parameter int DM_WAIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mm_en,
  input  logic             mm_we,
  input  logic [7:0]       mm_wdata,
  input  logic [15:0]      dm_addr,
  input  logic             dm_en,
  input  logic [7:0]       io_addr,
  input  logic             io_en,
  output logic             dm_ce,
  output logic             dm_we,
  output logic [DM_AW-1:0] dm_a,
  output logic [7:0]       dm_wd,
  input  logic [7:0]       dm_rd,
  output logic             io_re,
  output logic             io_we,
  output logic [7:0]       io_a,
  output logic [7:0]       io_wd,
  input  logic [7:0]       io_rd,
  output logic [7:0]       mm_rdata,
  output logic             mm_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RDW  = 2'd2,
    DONE = 2'd3
  } state_t;

  // OOR and the register-file window behave identically here, so they
  // share the TGT_NONE class.
  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_DM   = 2'd1,
    TGT_IO   = 2'd2
  } target_t;

  localparam logic [2:0] WAIT_INIT = 3'(DM_WAIT);

  state_t             state;
  state_t             state_nxt;
  target_t            target;
  target_t            target_nxt;
  target_t            req_target;
  logic               is_write;
  logic               is_write_nxt;
  logic [2:0]         wait_cnt;
  logic [2:0]         wait_cnt_nxt;
  logic               dm_in_range;

  logic               dm_ce_nxt;
  logic               dm_we_nxt;
  logic [DM_AW-1:0]   dm_a_nxt;
  logic [7:0]         dm_wd_nxt;
  logic               io_re_nxt;
  logic               io_we_nxt;
  logic [7:0]         io_a_nxt;
  logic [7:0]         io_wd_nxt;
  logic [7:0]         mm_rdata_nxt;
  logic               mm_ready_nxt;

  // Classify the incoming request; the SRAM decode wins if both enables are set.
  always_comb begin
    dm_in_range = ((dm_addr >> DM_AW) == 16'd0);
    if (dm_en) begin
      req_target = dm_in_range ? TGT_DM : TGT_NONE;
    end else if (io_en) begin
      req_target = TGT_IO;
    end else begin
      req_target = TGT_NONE;
    end
  end

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_nxt    = state;
    target_nxt   = target;
    is_write_nxt = is_write;
    wait_cnt_nxt = wait_cnt;
    dm_ce_nxt    = 1'b0;
    dm_we_nxt    = 1'b0;
    io_re_nxt    = 1'b0;
    io_we_nxt    = 1'b0;
    mm_ready_nxt = 1'b0;
    dm_a_nxt     = dm_a;
    dm_wd_nxt    = dm_wd;
    io_a_nxt     = io_a;
    io_wd_nxt    = io_wd;
    mm_rdata_nxt = mm_rdata;

    case (state)
      IDLE: begin
        if (mm_en) begin
          target_nxt   = req_target;
          is_write_nxt = mm_we;
          dm_a_nxt     = dm_addr[DM_AW-1:0];
          dm_wd_nxt    = mm_wdata;
          io_a_nxt     = io_addr;
          io_wd_nxt    = mm_wdata;
          if (req_target == TGT_DM) begin
            dm_ce_nxt = 1'b1;
            dm_we_nxt = mm_we;
          end else if (req_target == TGT_IO) begin
            io_re_nxt = ~mm_we;
            io_we_nxt = mm_we;
          end
          state_nxt = ACC;
        end
      end

      ACC: begin
        if ((target == TGT_DM) && !is_write) begin
          wait_cnt_nxt = WAIT_INIT;
          state_nxt    = RDW;
        end else begin
          if (!is_write) begin
            mm_rdata_nxt = (target == TGT_IO) ? io_rd : 8'h00;
          end
          mm_ready_nxt = 1'b1;
          state_nxt    = DONE;
        end
      end

      RDW: begin
        if (wait_cnt == 3'd0) begin
          mm_rdata_nxt = dm_rd;
          mm_ready_nxt = 1'b1;
          state_nxt    = DONE;
        end else begin
          wait_cnt_nxt = wait_cnt - 3'd1;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      target   <= TGT_NONE;
      is_write <= 1'b0;
      wait_cnt <= 3'd0;
      dm_ce    <= 1'b0;
      dm_we    <= 1'b0;
      dm_a     <= '0;
      dm_wd    <= 8'h00;
      io_re    <= 1'b0;
      io_we    <= 1'b0;
      io_a     <= 8'h00;
      io_wd    <= 8'h00;
      mm_rdata <= 8'h00;
      mm_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      target   <= target_nxt;
      is_write <= is_write_nxt;
      wait_cnt <= wait_cnt_nxt;
      dm_ce    <= dm_ce_nxt;
      dm_we    <= dm_we_nxt;
      dm_a     <= dm_a_nxt;
      dm_wd    <= dm_wd_nxt;
      io_re    <= io_re_nxt;
      io_we    <= io_we_nxt;
      io_a     <= io_a_nxt;
      io_wd    <= io_wd_nxt;
      mm_rdata <= mm_rdata_nxt;
      mm_ready <= mm_ready_nxt;
    end
  end

endmodule
